// File: rtl/somador_serial_nibble_if.sv
// Request/result and external-adder signals of the serial nibble adder.
// slave is the controller view, master is the view of whoever drives it.
interface somador_serial_nibble_if #(
    parameter int NIBBLES = 4
);
    localparam int W = 4 * NIBBLES;

    // request side
    logic         start;
    logic         sub;
    logic [W-1:0] op_a;
    logic [W-1:0] op_b;
    logic         cin_in;

    // external 4-bit adder side
    logic [3:0]   add_a;
    logic [3:0]   add_b;
    logic         add_cin;
    logic [3:0]   add_s;
    logic         add_cout;

    // result side
    logic [W-1:0] result;
    logic         cout;
    logic         overflow;
    logic         busy;
    logic         ready;
    logic         done;

    modport slave (
        input  start, sub, op_a, op_b, cin_in, add_s, add_cout,
        output add_a, add_b, add_cin, result, cout, overflow, busy, ready, done
    );

    modport master (
        output start, sub, op_a, op_b, cin_in, add_s, add_cout,
        input  add_a, add_b, add_cin, result, cout, overflow, busy, ready, done
    );
endinterface

// File: rtl/somador_serial_nibble.sv
// Multi-nibble add/subtract controller: feeds an external 4-bit adder one nibble
// per cycle, LSB first, chaining the carry and assembling a registered result.
module somador_serial_nibble #(
    parameter int NIBBLES = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    somador_serial_nibble_if.slave  bus
);
    localparam int W     = 4 * NIBBLES;
    localparam int IDX_W = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           state_q,  state_d;
    logic [IDX_W-1:0] idx_q,    idx_d;
    logic [W-1:0]     a_q,      a_d;
    logic [W-1:0]     b_q,      b_d;
    logic [W-1:0]     result_q, result_d;
    logic             carry_q,  carry_d;
    logic             cout_q,   cout_d;
    logic             ovf_q,    ovf_d;
    logic             busy_q,   busy_d;
    logic             ready_q,  ready_d;
    logic             done_q,   done_d;

    logic [3:0]       a_nib [NIBBLES];
    logic [3:0]       b_nib [NIBBLES];
    logic [W-1:0]     result_upd;
    logic             run;
    logic             is_last;

    // Per-slice views of the latched operands and the result with the
    // currently addressed nibble replaced by the adder's sum.
    for (genvar gi = 0; gi < NIBBLES; gi++) begin : g_nib
        assign a_nib[gi] = a_q[4*gi +: 4];
        assign b_nib[gi] = b_q[4*gi +: 4];
        assign result_upd[4*gi +: 4] = (idx_q == IDX_W'(gi)) ? bus.add_s
                                                              : result_q[4*gi +: 4];
    end

    assign run     = (state_q == S_RUN);
    assign is_last = (idx_q == IDX_W'(NIBBLES - 1));

    assign bus.add_a   = run ? a_nib[idx_q] : 4'h0;
    assign bus.add_b   = run ? b_nib[idx_q] : 4'h0;
    assign bus.add_cin = run ? carry_q      : 1'b0;

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        a_d      = a_q;
        b_d      = b_q;
        result_d = result_q;
        carry_d  = carry_q;
        cout_d   = cout_q;
        ovf_d    = ovf_q;

        case (state_q)
            S_IDLE, S_DONE: begin
                if (bus.start) begin
                    // Subtraction is A + ~B + 1; cin_in only matters for add.
                    a_d     = bus.op_a;
                    b_d     = bus.sub ? ~bus.op_b : bus.op_b;
                    carry_d = bus.sub ? 1'b1 : bus.cin_in;
                    idx_d   = '0;
                    ovf_d   = 1'b0;
                    state_d = S_RUN;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_RUN: begin
                result_d = result_upd;
                carry_d  = bus.add_cout;
                if (is_last) begin
                    cout_d  = bus.add_cout;
                    ovf_d   = (a_q[W-1] == b_q[W-1]) && (bus.add_s[3] != a_q[W-1]);
                    state_d = S_DONE;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase

        busy_d  = (state_d == S_RUN);
        ready_d = (state_d != S_RUN);
        done_d  = (state_d == S_DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            idx_q    <= '0;
            a_q      <= '0;
            b_q      <= '0;
            result_q <= '0;
            carry_q  <= 1'b0;
            cout_q   <= 1'b0;
            ovf_q    <= 1'b0;
            busy_q   <= 1'b0;
            ready_q  <= 1'b1;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            a_q      <= a_d;
            b_q      <= b_d;
            result_q <= result_d;
            carry_q  <= carry_d;
            cout_q   <= cout_d;
            ovf_q    <= ovf_d;
            busy_q   <= busy_d;
            ready_q  <= ready_d;
            done_q   <= done_d;
        end
    end

    assign bus.result   = result_q;
    assign bus.cout     = cout_q;
    assign bus.overflow = ovf_q;
    assign bus.busy     = busy_q;
    assign bus.ready    = ready_q;
    assign bus.done     = done_q;
endmodule

// File: tb/tb_somador_serial_nibble.sv
// Directed bench for somador_serial_nibble (NIBBLES=4) with a behavioural
// 4-bit adder on the external adder port.
module tb_somador_serial_nibble;
    logic clk = 1'b0;
    logic rst_n = 1'b1;

    somador_serial_nibble_if #(.NIBBLES(4)) ifc ();

    somador_serial_nibble #(.NIBBLES(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (ifc.slave)
    );

    always #5 clk = ~clk;

    // The external combinational 4-bit ripple adder.
    assign {ifc.add_cout, ifc.add_s} = 5'(ifc.add_a) + 5'(ifc.add_b) + 5'(ifc.add_cin);

    typedef struct {
        logic        sub;
        logic [15:0] a;
        logic [15:0] b;
        logic        cin;
        logic [15:0] res;
        logic        co;
        logic        ov;
        logic [15:0] aseq;   // add_a per RUN cycle, first nibble in [15:12]
        logic [3:0]  cseq;   // add_cin per RUN cycle, first in [3]
    } vec_t;

    vec_t vecs [8];
    int   n_cmp = 0;
    int   n_err = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Called just after a negedge; presents the request and follows it to done.
    // lat counts cycles from the cycle start is presented (0) to the done cycle.
    task automatic run_op(input logic s, input logic [15:0] a, input logic [15:0] b,
                          input logic c, input bit poke,
                          output logic [15:0] r, output logic co, output logic ov,
                          output int lat, output logic [15:0] aseq, output logic [3:0] cseq);
        ifc.sub    = s;
        ifc.op_a   = a;
        ifc.op_b   = b;
        ifc.cin_in = c;
        ifc.start  = 1'b1;
        @(posedge clk);
        #1;
        ifc.start = 1'b0;
        lat  = -1;
        aseq = '0;
        cseq = '0;
        for (int n = 1; n <= 20; n++) begin
            @(negedge clk);
            if (poke && n == 2) begin
                ifc.start  = 1'b1;
                ifc.sub    = ~s;
                ifc.op_a   = ~a;
                ifc.op_b   = 16'h5A5A;
                ifc.cin_in = ~c;
            end
            if (poke && n == 3) ifc.start = 1'b0;
            if (ifc.busy) begin
                aseq = {aseq[11:0], ifc.add_a};
                cseq = {cseq[2:0], ifc.add_cin};
            end
            if (ifc.done) begin
                lat = n;
                break;
            end
        end
        r  = ifc.result;
        co = ifc.cout;
        ov = ifc.overflow;
    endtask

    task automatic check_op(input string tag, input vec_t v, input logic [15:0] r,
                            input logic co, input logic ov, input int lat,
                            input logic [15:0] aseq, input logic [3:0] cseq);
        chk({tag, " latency"},  32'(lat),  32'd5);
        chk({tag, " result"},   32'(r),    32'(v.res));
        chk({tag, " cout"},     32'(co),   32'(v.co));
        chk({tag, " overflow"}, 32'(ov),   32'(v.ov));
        chk({tag, " add_a seq"},32'(aseq), 32'(v.aseq));
        chk({tag, " add_cin seq"}, 32'(cseq), 32'(v.cseq));
    endtask

    logic [15:0] r, aseq;
    logic        co, ov;
    logic [3:0]  cseq;
    int          lat;

    initial begin
        //            sub   a         b         cin   res       co    ov    aseq      cseq
        vecs[0] = '{1'b0, 16'h1234, 16'h0001, 1'b0, 16'h1235, 1'b0, 1'b0, 16'h4321, 4'b0000};
        vecs[1] = '{1'b0, 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0, 16'hFFFF, 4'b0111};
        vecs[2] = '{1'b0, 16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1, 16'hFFF7, 4'b0111};
        vecs[3] = '{1'b0, 16'h0003, 16'h0004, 1'b1, 16'h0008, 1'b0, 1'b0, 16'h3000, 4'b1000};
        vecs[4] = '{1'b1, 16'h0005, 16'h0007, 1'b0, 16'hFFFE, 1'b0, 1'b0, 16'h5000, 4'b1000};
        vecs[5] = '{1'b1, 16'h8000, 16'h0001, 1'b1, 16'h7FFF, 1'b1, 1'b1, 16'h0008, 4'b1000};
        vecs[6] = '{1'b0, 16'h9999, 16'h1111, 1'b0, 16'hAAAA, 1'b0, 1'b0, 16'h9999, 4'b0000};
        vecs[7] = '{1'b1, 16'h1234, 16'h1234, 1'b0, 16'h0000, 1'b1, 1'b0, 16'h4321, 4'b1111};

        ifc.start = 1'b0; ifc.sub = 1'b0; ifc.op_a = '0; ifc.op_b = '0; ifc.cin_in = 1'b0;

        // reset state
        #2 rst_n = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst ready",   32'(ifc.ready),    32'd1);
        chk("rst busy",    32'(ifc.busy),     32'd0);
        chk("rst done",    32'(ifc.done),     32'd0);
        chk("rst result",  32'(ifc.result),   32'd0);
        chk("rst cout",    32'(ifc.cout),     32'd0);
        chk("rst overflow",32'(ifc.overflow), 32'd0);
        chk("rst add_a",   32'(ifc.add_a),    32'd0);
        chk("rst add_cin", 32'(ifc.add_cin),  32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // table of single operations, each followed by an idle cycle
        for (int i = 0; i < 8; i++) begin
            run_op(vecs[i].sub, vecs[i].a, vecs[i].b, vecs[i].cin, 1'b0, r, co, ov, lat, aseq, cseq);
            check_op($sformatf("vec%0d", i), vecs[i], r, co, ov, lat, aseq, cseq);
            @(negedge clk);
            chk($sformatf("vec%0d done pulse", i), 32'(ifc.done),  32'd0);
            chk($sformatf("vec%0d ready after", i), 32'(ifc.ready), 32'd1);
            $display("vec%0d sub=%0b a=%h b=%h cin=%0b -> result=%h cout=%0b ovf=%0b lat=%0d",
                     i, vecs[i].sub, vecs[i].a, vecs[i].b, vecs[i].cin, r, co, ov, lat);
        end

        // start and changed operands during RUN are ignored
        run_op(vecs[0].sub, vecs[0].a, vecs[0].b, vecs[0].cin, 1'b1, r, co, ov, lat, aseq, cseq);
        check_op("poke", vecs[0], r, co, ov, lat, aseq, cseq);
        @(negedge clk);
        chk("poke no restart", 32'(ifc.busy), 32'd0);
        $display("poke: result=%h lat=%0d", r, lat);

        // back-to-back: second start presented in the DONE cycle
        run_op(vecs[3].sub, vecs[3].a, vecs[3].b, vecs[3].cin, 1'b0, r, co, ov, lat, aseq, cseq);
        check_op("b2b first", vecs[3], r, co, ov, lat, aseq, cseq);
        run_op(vecs[5].sub, vecs[5].a, vecs[5].b, vecs[5].cin, 1'b0, r, co, ov, lat, aseq, cseq);
        check_op("b2b second", vecs[5], r, co, ov, lat, aseq, cseq);
        $display("b2b: second result=%h lat=%0d", r, lat);
        @(negedge clk);

        // asynchronous reset in the second RUN cycle
        ifc.sub = 1'b0; ifc.op_a = 16'h1234; ifc.op_b = 16'h0001; ifc.cin_in = 1'b0;
        ifc.start = 1'b1;
        @(posedge clk);
        #1 ifc.start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("midrst busy",     32'(ifc.busy),     32'd0);
        chk("midrst ready",    32'(ifc.ready),    32'd1);
        chk("midrst done",     32'(ifc.done),     32'd0);
        chk("midrst result",   32'(ifc.result),   32'd0);
        chk("midrst cout",     32'(ifc.cout),     32'd0);
        chk("midrst overflow", 32'(ifc.overflow), 32'd0);
        chk("midrst add_a",    32'(ifc.add_a),    32'd0);
        chk("midrst add_cin",  32'(ifc.add_cin),  32'd0);
        $display("midrst: busy=%0b ready=%0b result=%h", ifc.busy, ifc.ready, ifc.result);
        #2 rst_n = 1'b1;
        @(negedge clk);
        run_op(vecs[1].sub, vecs[1].a, vecs[1].b, vecs[1].cin, 1'b0, r, co, ov, lat, aseq, cseq);
        check_op("after rst", vecs[1], r, co, ov, lat, aseq, cseq);
        $display("after rst: result=%h cout=%0b lat=%0d", r, co, lat);

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
        $finish;
    end
endmodule
